// File: rtl/pipe_dest_tracker.sv
// Destination/control tracker for the ID->EX->MEM->WB pipeline.
// Also detects load-use hazards and drives the PC and IF/ID stall controls.
module pipe_dest_tracker #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_uses_rt_i,
   input  logic [REG_AW-1:0] id_regdst_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_regdst_o,
   output logic              ex_regwrite_o,
   output logic              ex_memread_o,
   output logic [REG_AW-1:0] mem_regdst_o,
   output logic              mem_regwrite_o,
   output logic [REG_AW-1:0] wb_regdst_o,
   output logic              wb_regwrite_o,
   output logic              stall_o,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      FROZEN = 2'd2
   } mode_t;

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   mode_t mode;
   logic  match_rs;
   logic  match_rt;
   logic  haz;
   logic  take_id;

   // Hazard detection and per-cycle decode; a freeze outranks a stall.
   always_comb begin
      match_rs = (ex_regdst_o == id_rs_i);
      match_rt = id_uses_rt_i & (ex_regdst_o == id_rt_i);
      haz      = id_valid_i & ~flush_i & ex_memread_o &
                 (ex_regdst_o != REG_ZERO) & (match_rs | match_rt);
      take_id  = id_valid_i & ~flush_i & ~haz;
      if (hold_i) begin
         mode = FROZEN;
      end else if (haz) begin
         mode = STALL;
      end else begin
         mode = RUN;
      end
   end

   assign stall_o      = haz;
   assign pc_write_o   = (mode == RUN);
   assign ifid_write_o = (mode == RUN);

   // Stage registers and stall counter; reset wins over hold and flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_rs_o        <= REG_ZERO;
         ex_rt_o        <= REG_ZERO;
         ex_regdst_o    <= REG_ZERO;
         ex_regwrite_o  <= 1'b0;
         ex_memread_o   <= 1'b0;
         mem_regdst_o   <= REG_ZERO;
         mem_regwrite_o <= 1'b0;
         wb_regdst_o    <= REG_ZERO;
         wb_regwrite_o  <= 1'b0;
         stall_cnt_o    <= {CNT_W{1'b0}};
      end else if (mode != FROZEN) begin
         wb_regdst_o    <= mem_regdst_o;
         wb_regwrite_o  <= mem_regwrite_o;
         mem_regdst_o   <= ex_regdst_o;
         mem_regwrite_o <= ex_regwrite_o;
         if (take_id) begin
            ex_rs_o       <= id_rs_i;
            ex_rt_o       <= id_rt_i;
            ex_regdst_o   <= id_regdst_i;
            ex_regwrite_o <= id_regwrite_i;
            ex_memread_o  <= id_memread_i;
         end else begin
            ex_rs_o       <= REG_ZERO;
            ex_rt_o       <= REG_ZERO;
            ex_regdst_o   <= REG_ZERO;
            ex_regwrite_o <= 1'b0;
            ex_memread_o  <= 1'b0;
         end
         if ((mode == STALL) && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end else begin
            stall_cnt_o <= stall_cnt_o;
         end
      end else begin
         stall_cnt_o <= stall_cnt_o;
      end
   end

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Bench for pipe_dest_tracker: directed table, hand-written corner sequences and
// random stimulus against a stage-list model; a CNT_W=2 copy checks saturation.
module tb_pipe_dest_tracker;

   logic clk = 1'b0;
   logic rst, hold, flush, valid, uses, rw, mr;
   logic [4:0] rs, rt, dst;

   logic [4:0]  ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
   logic        ex_rw, ex_mr, mem_rw, wb_rw, stall, pcw, ifidw;
   logic [15:0] cnt;
   logic [4:0]  s_ex_rs, s_ex_rt, s_ex_dst, s_mem_dst, s_wb_dst;
   logic        s_ex_rw, s_ex_mr, s_mem_rw, s_wb_rw, s_stall, s_pcw, s_ifidw;
   logic [1:0]  s_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pipe_dest_tracker dut (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(valid),
      .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses), .id_regdst_i(dst),
      .id_regwrite_i(rw), .id_memread_i(mr),
      .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_regdst_o(ex_dst), .ex_regwrite_o(ex_rw),
      .ex_memread_o(ex_mr), .mem_regdst_o(mem_dst), .mem_regwrite_o(mem_rw),
      .wb_regdst_o(wb_dst), .wb_regwrite_o(wb_rw), .stall_o(stall),
      .pc_write_o(pcw), .ifid_write_o(ifidw), .stall_cnt_o(cnt));

   pipe_dest_tracker #(.REG_AW(5), .CNT_W(2)) dut_s (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush), .id_valid_i(valid),
      .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses), .id_regdst_i(dst),
      .id_regwrite_i(rw), .id_memread_i(mr),
      .ex_rs_o(s_ex_rs), .ex_rt_o(s_ex_rt), .ex_regdst_o(s_ex_dst), .ex_regwrite_o(s_ex_rw),
      .ex_memread_o(s_ex_mr), .mem_regdst_o(s_mem_dst), .mem_regwrite_o(s_mem_rw),
      .wb_regdst_o(s_wb_dst), .wb_regwrite_o(s_wb_rw), .stall_o(s_stall),
      .pc_write_o(s_pcw), .ifid_write_o(s_ifidw), .stall_cnt_o(s_cnt));

   // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct packed {
      logic [4:0] rs, rt, dst;
      logic       rw, mr;
   } ent_t;
   ent_t pipe [3];
   int unsigned total_stalls = 0;

   typedef struct {
      logic       flush, valid;
      logic [4:0] rs, rt;
      logic       uses;
      logic [4:0] dst;
      logic       rw, mr;
      logic       e_stall, e_pcw, e_exrw;
      logic [4:0] e_memdst;
      logic       e_memrw;
      logic [4:0] e_wbdst;
      logic [15:0] e_cnt;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic model_haz();
      ent_t e = pipe[0];
      if (!valid || flush || !e.mr || e.dst == 5'd0) return 1'b0;
      return (e.dst == rs) || (uses && e.dst == rt);
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_all();
      logic h = model_haz();
      logic [31:0] pipe_exp;
      chk("stall", {31'd0, stall}, {31'd0, h});
      chk("pc_write", {31'd0, pcw}, {31'd0, ~h & ~hold});
      chk("ifid_write", {31'd0, ifidw}, {31'd0, ~h & ~hold});
      chk("ex_rs", {27'd0, ex_rs}, {27'd0, pipe[0].rs});
      chk("ex_rt", {27'd0, ex_rt}, {27'd0, pipe[0].rt});
      chk("ex_regdst", {27'd0, ex_dst}, {27'd0, pipe[0].dst});
      chk("ex_ctl", {30'd0, ex_rw, ex_mr}, {30'd0, pipe[0].rw, pipe[0].mr});
      chk("mem", {26'd0, mem_dst, mem_rw}, {26'd0, pipe[1].dst, pipe[1].rw});
      chk("wb", {26'd0, wb_dst, wb_rw}, {26'd0, pipe[2].dst, pipe[2].rw});
      chk("stall_cnt", {16'd0, cnt}, sat(total_stalls, 32'd65535));
      chk("stall_cnt_w2", {30'd0, s_cnt}, sat(total_stalls, 32'd3));
      pipe_exp = {2'd0, pipe[0].dst, pipe[0].rw, pipe[0].mr, pipe[1].dst, pipe[1].rw,
                  pipe[2].dst, pipe[2].rw, h, ~h & ~hold, ~h & ~hold};
      chk("w2_pipe", {2'd0, s_ex_dst, s_ex_rw, s_ex_mr, s_mem_dst, s_mem_rw,
                      s_wb_dst, s_wb_rw, s_stall, s_pcw, s_ifidw}, pipe_exp);
      chk("w2_src", {22'd0, s_ex_rs, s_ex_rt}, {22'd0, pipe[0].rs, pipe[0].rt});
   endtask

   task automatic model_step();
      logic h = model_haz();
      if (rst) begin
         for (int i = 0; i < 3; i++) pipe[i] = '0;
         total_stalls = 0;
      end else if (!hold) begin
         if (h) total_stalls++;
         for (int i = 2; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = (valid && !flush && !h) ? ent_t'({rs, rt, dst, rw, mr}) : '0;
      end
   endtask

   task automatic cycle(input bit do_chk);
      #3;
      if (do_chk) check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic u, input logic [4:0] d, input logic w, input logic m);
      valid = v; rs = a; rt = b; uses = u; dst = d; rw = w; mr = m;
   endtask

   initial begin
      ent_t snap [3];
      rst = 1'b1; hold = 1'b1; flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      @(posedge clk); #1;
      cycle(1'b0);
      cycle(1'b0);
      // Reset state with hold still asserted: every output zero.
      rst = 1'b0;
      cycle(1'b1);
      hold = 1'b0;

      tbl[0]  = '{1'b0, 1'b1, 5'd1,  5'd8,  1'b0, 5'd8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  16'd0};
      tbl[1]  = '{1'b0, 1'b1, 5'd8,  5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  16'd0};
      tbl[2]  = '{1'b0, 1'b1, 5'd8,  5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8,  1'b1, 5'd0,  16'd1};
      tbl[3]  = '{1'b0, 1'b1, 5'd4,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd8,  16'd1};
      tbl[4]  = '{1'b0, 1'b1, 5'd0,  5'd5,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  1'b1, 5'd0,  16'd1};
      tbl[5]  = '{1'b0, 1'b1, 5'd1,  5'd9,  1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 5'd3,  16'd1};
      tbl[6]  = '{1'b0, 1'b1, 5'd2,  5'd9,  1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  1'b1, 5'd0,  16'd1};
      tbl[7]  = '{1'b0, 1'b1, 5'd1,  5'd11, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 5'd6,  16'd1};
      tbl[8]  = '{1'b1, 1'b1, 5'd11, 5'd0,  1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b1, 5'd9,  16'd1};
      tbl[9]  = '{1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11, 1'b1, 5'd10, 16'd1};
      tbl[10] = '{1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd11, 16'd1};

      for (int i = 0; i < 11; i++) begin
         flush = tbl[i].flush;
         set_id(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].dst, tbl[i].rw, tbl[i].mr);
         #2;
         chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
         chk($sformatf("tbl%0d_pcw", i), {31'd0, pcw}, {31'd0, tbl[i].e_pcw});
         chk($sformatf("tbl%0d_exrw", i), {31'd0, ex_rw}, {31'd0, tbl[i].e_exrw});
         chk($sformatf("tbl%0d_mem", i), {26'd0, mem_dst, mem_rw}, {26'd0, tbl[i].e_memdst, tbl[i].e_memrw});
         chk($sformatf("tbl%0d_wbdst", i), {27'd0, wb_dst}, {27'd0, tbl[i].e_wbdst});
         chk($sformatf("tbl%0d_cnt", i), {16'd0, cnt}, {16'd0, tbl[i].e_cnt});
         #1;
         check_all();
         model_step();
         @(posedge clk); #1;
      end
      flush = 1'b0;

      // Freeze for 3 cycles while a load-use hazard is pending, then release.
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);  cycle(1'b1);
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);  cycle(1'b1);
      for (int i = 0; i < 3; i++) snap[i] = pipe[i];
      hold = 1'b1;
      set_id(1'b1, 5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("hold_pcw", {31'd0, pcw}, 32'd0);
         chk("hold_stall", {31'd0, stall}, 32'd1);
         chk("hold_frozen", {9'd0, ex_dst, ex_rw, ex_mr, mem_dst, mem_rw, wb_dst, wb_rw},
             {9'd0, snap[0].dst, snap[0].rw, snap[0].mr, snap[1].dst, snap[1].rw, snap[2].dst, snap[2].rw});
         chk("hold_cnt", {16'd0, cnt}, 32'd1);
         #1;
         model_step();
         @(posedge clk); #1;
      end
      hold = 1'b0;
      cycle(1'b1);
      cycle(1'b1);
      chk("post_hold_cnt", {16'd0, cnt}, 32'd2);

      // Five separate load-use stalls saturate the 2-bit counter.
      for (int k = 0; k < 5; k++) begin
         set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  cycle(1'b1);
         set_id(1'b1, 5'd7, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);  cycle(1'b1);
         cycle(1'b1);
      end
      #2;
      chk("sat_w2", {30'd0, s_cnt}, 32'd3);
      chk("cnt_w16", {16'd0, cnt}, 32'd7);

      // Reset asserted while a stall is active clears every stage and the counter.
      set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  cycle(1'b1);
      set_id(1'b1, 5'd7, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
      #2;
      chk("pre_rst_stall", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      cycle(1'b0);
      rst = 1'b0;
      #2;
      chk("rst_cnt", {14'd0, cnt, s_cnt}, 32'd0);
      chk("rst_stages", {13'd0, ex_dst, ex_rw, ex_mr, mem_dst, mem_rw, wb_dst, wb_rw}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      cycle(1'b1);

      // Random stimulus with a small register range so hazards are frequent.
      for (int n = 0; n < 500; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         hold  = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 7) == 0);
         set_id(1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
         cycle(1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
